// File: rtl/gf_pe_vec_pkg.sv
// Shared definitions for the vectorised GF(2^m) processing element: op
// encodings, reduction polynomials and a polynomial-basis multiply helper.
package gf_pe_vec_pkg;

    typedef enum logic [2:0] {
        MODE_PASS = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_MAC  = 3'd2,
        MODE_ADD  = 3'd3,
        MODE_EMIT = 3'd4
    } gf_mode_e;

    localparam logic [8:0] POLY_GF4   = 9'h007;
    localparam logic [8:0] POLY_GF16  = 9'h013;
    localparam logic [8:0] POLY_GF256 = 9'h11B;

    function automatic logic gf_bit_legal(input int unsigned w);
        return (w == 32'd4) || (w == 32'd8);
    endfunction

    // Shift-and-add multiply in GF(2^w), w <= 8; operands must be zero above bit w-1.
    function automatic logic [7:0] gf_poly_mul(input logic [7:0] a, input logic [7:0] b,
                                               input int unsigned w, input logic [8:0] poly);
        logic [7:0] acc;
        logic [7:0] aa;
        logic [7:0] mask;
        logic       msb;
        mask = 8'((9'd1 << w) - 9'd1);
        acc  = 8'd0;
        aa   = a & mask;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (aa & {8{b[i]}});
            msb = |(aa & (mask ^ (mask >> 1)));
            aa  = ((aa << 1) ^ (poly[7:0] & {8{msb}})) & mask;
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf_pe_vec_mul.sv
// Single-lane combinational GF(2^m) multiplier, either AES polynomial basis
// or a two-level tower (GF16 = GF4^2, GF256 = GF16^2).
module gf_mul
    import gf_pe_vec_pkg::*;
#(
    parameter int GF_BIT = 4,
    parameter bit TOWER  = 1'b0
) (
    input  logic [GF_BIT-1:0] a,
    input  logic [GF_BIT-1:0] b,
    output logic [GF_BIT-1:0] p
);

    if (TOWER) begin : g_tower
        localparam int         H        = GF_BIT / 2;
        localparam logic [8:0] POLY_SUB = (GF_BIT == 8) ? POLY_GF16 : POLY_GF4;
        // Extension y^2 + y + LAMBDA; LAMBDA has subfield trace 1 so it is irreducible.
        localparam logic [7:0] LAMBDA   = (GF_BIT == 8) ? 8'h08 : 8'h02;
        logic [7:0] hh_s;
        logic [7:0] mid_s;
        logic [7:0] ll_s;

        // Karatsuba-free composite product: hi = a1b1+a1b0+a0b1, lo = a0b0+LAMBDA*a1b1
        always_comb begin
            hh_s  = gf_poly_mul(8'(a[GF_BIT-1:H]), 8'(b[GF_BIT-1:H]), H, POLY_SUB);
            mid_s = gf_poly_mul(8'(a[GF_BIT-1:H]), 8'(b[H-1:0]), H, POLY_SUB)
                  ^ gf_poly_mul(8'(a[H-1:0]), 8'(b[GF_BIT-1:H]), H, POLY_SUB);
            ll_s  = gf_poly_mul(8'(a[H-1:0]), 8'(b[H-1:0]), H, POLY_SUB);
            p     = {H'(hh_s ^ mid_s), H'(ll_s ^ gf_poly_mul(LAMBDA, hh_s, H, POLY_SUB))};
        end
    end else begin : g_poly
        // Direct polynomial-basis product reduced by 0x13 or 0x11B
        always_comb begin
            p = GF_BIT'(gf_poly_mul(8'(a), 8'(b), GF_BIT,
                                    (GF_BIT == 8) ? POLY_GF256 : POLY_GF16));
        end
    end

endmodule

// File: rtl/gf_pe_vec.sv
// Vectorised GF(2^m) systolic PE: per-lane PASS/LOAD/MAC/ADD/EMIT with an
// optional multiplier register stage; r is forwarded so both depths agree.
module gf_pe_vec
    import gf_pe_vec_pkg::*;
#(
    parameter int GF_BIT   = 4,
    parameter int LANES    = 2,
    parameter int MUL_PIPE = 1,
    parameter bit TOWER    = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [2:0]                in_mode,
    input  logic                      in_start,
    input  logic [LANES*GF_BIT-1:0]   a_in,
    input  logic [LANES*GF_BIT-1:0]   b_in,
    input  logic [LANES*GF_BIT-1:0]   data_in,
    output logic                      out_valid,
    output logic [2:0]                out_mode,
    output logic                      out_start,
    output logic [LANES*GF_BIT-1:0]   a_out,
    output logic [LANES*GF_BIT-1:0]   b_out,
    output logic [LANES*GF_BIT-1:0]   data_out,
    output logic [LANES*GF_BIT-1:0]   r
);

    localparam int L = 1 + MUL_PIPE;
    localparam int W = LANES * GF_BIT;

    if (!gf_bit_legal(GF_BIT)) begin : g_bad_gf_bit
        $error("gf_pe_vec: GF_BIT must be 4 or 8");
    end

    typedef struct packed {
        logic         valid;
        logic [2:0]   mode;
        logic         start;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } ctl_t;

    localparam ctl_t CTL_ZERO = {$bits(ctl_t){1'b0}};

    ctl_t         ctl_in_s;
    ctl_t         ctl_r [L];
    logic [W-1:0] r_r;
    logic [W-1:0] data_out_r;
    logic [W-1:0] r_src_s;
    logic [W-1:0] mul_b_s;
    logic [W-1:0] mul_prod_s;
    logic         wr_valid_s;
    logic [2:0]   wr_mode_s;
    logic         wr_start_s;
    logic [W-1:0] wr_prod_s;
    logic [W-1:0] wr_data_s;
    logic [W-1:0] wr_pre_s;
    logic [W-1:0] r_next_s;
    logic [W-1:0] dout_next_s;

    // Bundle the control/operand fields that travel to the neighbour PE
    always_comb begin
        ctl_in_s.valid = in_valid;
        ctl_in_s.mode  = in_mode;
        ctl_in_s.start = in_start;
        ctl_in_s.a     = a_in;
        ctl_in_s.b     = b_in;
    end

    // Control/operand delay line, shifted every cycle regardless of valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < L; k++) ctl_r[k] <= CTL_ZERO;
        end else begin
            ctl_r[0] <= ctl_in_s;
            for (int k = 1; k < L; k++) ctl_r[k] <= ctl_r[k-1];
        end
    end

    // ADD multiplies a by the (possibly start-cleared) accumulator instead of b
    always_comb begin
        mul_b_s = (in_mode == MODE_ADD) ? (in_start ? {W{1'b0}} : r_src_s) : b_in;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gf_mul #(.GF_BIT(GF_BIT), .TOWER(TOWER)) u_mul (
            .a (a_in[i*GF_BIT +: GF_BIT]),
            .b (mul_b_s[i*GF_BIT +: GF_BIT]),
            .p (mul_prod_s[i*GF_BIT +: GF_BIT])
        );
    end

    if (MUL_PIPE != 0) begin : g_pipe
        logic [W-1:0] prod_r;
        logic [W-1:0] data_r;

        // Stage-1 product and column data; control rides in ctl_r[0]
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prod_r <= {W{1'b0}};
                data_r <= {W{1'b0}};
            end else begin
                prod_r <= mul_prod_s;
                data_r <= data_in;
            end
        end

        assign wr_valid_s = ctl_r[0].valid;
        assign wr_mode_s  = ctl_r[0].mode;
        assign wr_start_s = ctl_r[0].start;
        assign wr_prod_s  = prod_r;
        assign wr_data_s  = data_r;
        // r_next_s equals r_r unless stage 2 writes r, so this is the forward path
        assign r_src_s    = r_next_s;
    end else begin : g_comb
        assign wr_valid_s = in_valid;
        assign wr_mode_s  = in_mode;
        assign wr_start_s = in_start;
        assign wr_prod_s  = mul_prod_s;
        assign wr_data_s  = data_in;
        assign r_src_s    = r_r;
    end

    // Write stage: next accumulator and data_out for the op being retired
    always_comb begin
        wr_pre_s    = wr_start_s ? {W{1'b0}} : r_r;
        r_next_s    = r_r;
        dout_next_s = data_out_r;
        if (wr_valid_s) begin
            r_next_s = wr_pre_s;
            case (wr_mode_s)
                MODE_PASS: dout_next_s = wr_data_s;
                MODE_LOAD: r_next_s    = wr_prod_s;
                MODE_MAC:  r_next_s    = wr_pre_s ^ wr_prod_s;
                MODE_ADD:  dout_next_s = wr_data_s ^ wr_prod_s;
                MODE_EMIT: begin
                    dout_next_s = wr_pre_s;
                    r_next_s    = {W{1'b0}};
                end
                default:   dout_next_s = wr_data_s;
            endcase
        end else begin
            r_next_s    = r_r;
            dout_next_s = data_out_r;
        end
    end

    // Accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r        <= {W{1'b0}};
            data_out_r <= {W{1'b0}};
        end else begin
            r_r        <= r_next_s;
            data_out_r <= dout_next_s;
        end
    end

    assign out_valid = ctl_r[L-1].valid;
    assign out_mode  = ctl_r[L-1].mode;
    assign out_start = ctl_r[L-1].start;
    assign a_out     = ctl_r[L-1].a;
    assign b_out     = ctl_r[L-1].b;
    assign data_out  = data_out_r;
    assign r         = r_r;

endmodule

// File: tb/tb_gf_pe_vec.sv
// Directed bench: GF16 PEs at both pipeline depths share stimulus; a GF256 PE
// covers the AES field. Expected values are hand-computed constants.
module tb_gf_pe_vec;

    logic       clk;
    logic       rst_n;
    logic       v, st;
    logic [2:0] md;
    logic [7:0] a, b, d;
    logic       v8, st8;
    logic [2:0] md8;
    logic [15:0] a8, b8, d8;

    logic       p0_ov, p0_os, p1_ov, p1_os, g8_ov, g8_os;
    logic [2:0] p0_om, p1_om, g8_om;
    logic [7:0] p0_ao, p0_bo, p0_do, p0_r, p1_ao, p1_bo, p1_do, p1_r;
    logic [15:0] g8_ao, g8_bo, g8_do, g8_r;

    int n_chk  = 0;
    int n_pass = 0;

    gf_pe_vec #(.GF_BIT(4), .LANES(2), .MUL_PIPE(0), .TOWER(1'b0)) u_p0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v), .in_mode(md), .in_start(st),
        .a_in(a), .b_in(b), .data_in(d), .out_valid(p0_ov), .out_mode(p0_om),
        .out_start(p0_os), .a_out(p0_ao), .b_out(p0_bo), .data_out(p0_do), .r(p0_r));

    gf_pe_vec #(.GF_BIT(4), .LANES(2), .MUL_PIPE(1), .TOWER(1'b0)) u_p1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v), .in_mode(md), .in_start(st),
        .a_in(a), .b_in(b), .data_in(d), .out_valid(p1_ov), .out_mode(p1_om),
        .out_start(p1_os), .a_out(p1_ao), .b_out(p1_bo), .data_out(p1_do), .r(p1_r));

    gf_pe_vec #(.GF_BIT(8), .LANES(2), .MUL_PIPE(1), .TOWER(1'b0)) u_g8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_mode(md8), .in_start(st8),
        .a_in(a8), .b_in(b8), .data_in(d8), .out_valid(g8_ov), .out_mode(g8_om),
        .out_start(g8_os), .a_out(g8_ao), .b_out(g8_bo), .data_out(g8_do), .r(g8_r));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic vv, input logic [2:0] mm, input logic ss,
                       input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] dd);
        v = vv; md = mm; st = ss; a = aa; b = bb; d = dd;
    endtask

    task automatic drv8(input logic vv, input logic [2:0] mm, input logic ss,
                        input logic [15:0] aa, input logic [15:0] bb, input logic [15:0] dd);
        v8 = vv; md8 = mm; st8 = ss; a8 = aa; b8 = bb; d8 = dd;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00);
        drv8(1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        #2;
        check_eq("rst p0 r", 32'(p0_r), 32'h0);
        check_eq("rst p1 dout", 32'(p1_do), 32'h0);
        check_eq("rst g8 r", 32'(g8_r), 32'h0);
        check_eq("rst ov", 32'({p0_ov, p1_ov, g8_ov}), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post-rst ov", 32'({p0_ov, p1_ov, g8_ov}), 32'h0);

        // Test 1: start+LOAD, MAC, EMIT (lane1 uses different operands)
        drv(1'b1, 3'd1, 1'b1, 8'h12, 8'hC9, 8'h00); tick();
        check_eq("t1 p0 load r", 32'(p0_r), 32'hC1);
        check_eq("t1 p0 ov", 32'({p0_ov, p0_om, p0_os}), 32'h13);
        check_eq("t1 p0 a_out", 32'(p0_ao), 32'h12);
        check_eq("t1 p1 ov early", 32'(p1_ov), 32'h0);
        drv(1'b1, 3'd2, 1'b0, 8'h23, 8'hC7, 8'h00); tick();
        check_eq("t1 p0 mac r", 32'(p0_r), 32'h78);
        check_eq("t1 p1 load r", 32'(p1_r), 32'hC1);
        check_eq("t1 p1 a_out", 32'(p1_ao), 32'h12);
        drv(1'b1, 3'd4, 1'b0, 8'h00, 8'h00, 8'h00); tick();
        check_eq("t1 p0 emit dout", 32'(p0_do), 32'h78);
        check_eq("t1 p0 emit r", 32'(p0_r), 32'h0);
        check_eq("t1 p1 mac r", 32'(p1_r), 32'h78);
        drv(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00); tick();
        check_eq("t1 p0 ov idle", 32'(p0_ov), 32'h0);
        check_eq("t1 p1 emit dout", 32'(p1_do), 32'h78);
        check_eq("t1 p1 emit r", 32'(p1_r), 32'h0);
        tick();

        // Test 2: LOAD then ADD back-to-back exercises forwarding
        drv(1'b1, 3'd1, 1'b0, 8'h12, 8'hC9, 8'h00); tick();
        drv(1'b1, 3'd3, 1'b0, 8'h23, 8'hFF, 8'h54); tick();
        check_eq("t2 p0 add dout", 32'(p0_do), 32'hE7);
        check_eq("t2 p0 add r", 32'(p0_r), 32'hC1);
        check_eq("t2 p1 dout hold", 32'(p1_do), 32'h78);
        drv(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00); tick();
        check_eq("t2 p1 add dout", 32'(p1_do), 32'hE7);
        check_eq("t2 p1 add r", 32'(p1_r), 32'hC1);

        // Test 3: GF256 AES field, lanes with distinct operands
        drv8(1'b1, 3'd1, 1'b1, 16'h0257, 16'h8783, 16'h0000); tick();
        check_eq("t3 g8 ov early", 32'(g8_ov), 32'h0);
        drv8(1'b1, 3'd2, 1'b0, 16'h0157, 16'hAA13, 16'h0000); tick();
        check_eq("t3 g8 load r", 32'(g8_r), 32'h15C1);
        check_eq("t3 g8 ov", 32'({g8_ov, g8_om}), 32'h9);
        drv8(1'b1, 3'd4, 1'b0, 16'h0000, 16'h0000, 16'h0000); tick();
        check_eq("t3 g8 mac r", 32'(g8_r), 32'hBF3F);
        drv8(1'b1, 3'd1, 1'b0, 16'h0157, 16'h0183, 16'h0000); tick();
        check_eq("t3 g8 emit dout", 32'(g8_do), 32'hBF3F);
        check_eq("t3 g8 emit r", 32'(g8_r), 32'h0);
        drv8(1'b1, 3'd3, 1'b0, 16'h0302, 16'hFFFF, 16'h1000); tick();
        check_eq("t3 g8 load2 r", 32'(g8_r), 32'h01C1);
        drv8(1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000); tick();
        check_eq("t3 g8 add dout", 32'(g8_do), 32'h1399);

        // Test 4: bubbles with garbage operands between LOAD and EMIT
        drv(1'b1, 3'd1, 1'b0, 8'h12, 8'hC9, 8'h00); tick();
        check_eq("t4 p0 load r", 32'(p0_r), 32'hC1);
        for (int k = 0; k < 3; k++) begin
            drv(1'b0, 3'd4, 1'b1, 8'hFF, 8'hFF, 8'hAA); tick();
            check_eq("t4 p0 bubble ov", 32'(p0_ov), 32'h0);
            check_eq("t4 p0 bubble r", 32'(p0_r), 32'hC1);
            check_eq("t4 p0 bubble dout", 32'(p0_do), 32'hE7);
            check_eq("t4 p1 bubble r", 32'(p1_r), 32'hC1);
            check_eq("t4 p1 bubble dout", 32'(p1_do), 32'hE7);
            check_eq("t4 p1 bubble ov", 32'(p1_ov), (k == 0) ? 32'h1 : 32'h0);
        end
        drv(1'b1, 3'd4, 1'b0, 8'h00, 8'h00, 8'h00); tick();
        check_eq("t4 p0 emit dout", 32'(p0_do), 32'hC1);
        check_eq("t4 p0 emit r", 32'(p0_r), 32'h0);
        check_eq("t4 p1 ov still low", 32'(p1_ov), 32'h0);
        drv(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00); tick();
        check_eq("t4 p1 emit dout", 32'(p1_do), 32'hC1);
        check_eq("t4 p1 emit ov", 32'(p1_ov), 32'h1);

        // Test 5: reserved mode 6 acts as PASS; PASS with start clears r
        drv(1'b1, 3'd1, 1'b0, 8'h12, 8'hC9, 8'h00); tick();
        drv(1'b1, 3'd6, 1'b0, 8'h77, 8'h77, 8'h5A); tick();
        check_eq("t5 p0 rsv dout", 32'(p0_do), 32'h5A);
        check_eq("t5 p0 rsv r", 32'(p0_r), 32'hC1);
        drv(1'b1, 3'd0, 1'b1, 8'h00, 8'h00, 8'h33); tick();
        check_eq("t5 p0 pass-start dout", 32'(p0_do), 32'h33);
        check_eq("t5 p0 pass-start r", 32'(p0_r), 32'h0);
        check_eq("t5 p1 rsv dout", 32'(p1_do), 32'h5A);
        check_eq("t5 p1 rsv r", 32'(p1_r), 32'hC1);
        drv(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00); tick();
        check_eq("t5 p1 pass-start r", 32'(p1_r), 32'h0);

        // Test 6: reset while a MAC sits in the multiplier stage
        drv(1'b1, 3'd1, 1'b0, 8'h12, 8'hC9, 8'h00); tick();
        drv(1'b1, 3'd2, 1'b0, 8'h23, 8'hC7, 8'h00); tick();
        check_eq("t6 p1 pre-rst r", 32'(p1_r), 32'hC1);
        drv(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b0;
        #1;
        check_eq("t6 rst p0 r/dout", 32'({p0_r, p0_do}), 32'h0);
        check_eq("t6 rst p1 r/dout", 32'({p1_r, p1_do}), 32'h0);
        check_eq("t6 rst ctl", 32'({p0_ov, p1_ov, p1_om, p1_ao, p1_bo}), 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        check_eq("t6 no late write", 32'({p1_r, p1_do}), 32'h0);
        check_eq("t6 ov after release", 32'({p0_ov, p1_ov}), 32'h0);
        drv(1'b1, 3'd0, 1'b0, 8'h00, 8'h00, 8'h99); tick();
        check_eq("t6 p0 ov", 32'({p0_ov, p1_ov}), 32'h2);
        check_eq("t6 p0 dout", 32'(p0_do), 32'h99);
        drv(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00); tick();
        check_eq("t6 p1 ov", 32'(p1_ov), 32'h1);
        check_eq("t6 p1 dout", 32'(p1_do), 32'h99);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gf_pe_vec.md
Name: gf_pe_vec

Overview:
- Next-generation systolic processing element for the GF(2^m) matrix/Gauss engine.
- Generalises the single-lane multiply/accumulate PE to LANES parallel GF lanes, an explicit mode field and an optional multiplier pipeline stage.
- Adds a valid qualifier and internal forwarding, so results are identical for MUL_PIPE=0 and MUL_PIPE=1.
- Sits in the PE array; control and operands are registered and forwarded to the neighbour with the same latency as data_out.

Parameters:
GF_BIT, 4, field width; legal values are 4 (GF16) and 8 (GF256).
LANES, 2, number of independent GF lanes processed per cycle.
MUL_PIPE, 1, 0 = single-cycle PE; 1 = register stage after the multiplier (latency 2).
TOWER, 0, 0 = AES polynomial basis (0x13 / 0x11B); 1 = tower-field multiplier.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  qualifies all in_* signals and operands this cycle
in_mode  in  3  0 PASS, 1 LOAD, 2 MAC, 3 ADD, 4 EMIT, 5-7 reserved
in_start  in  1  clear accumulator before applying this op
a_in  in  LANES*GF_BIT  operand A, lane i at bits [i*GF_BIT +: GF_BIT]
b_in  in  LANES*GF_BIT  operand B
data_in  in  LANES*GF_BIT  column data from the upstream PE
out_valid  out  1  in_valid delayed by L cycles
out_mode  out  3  in_mode delayed by L cycles
out_start  out  1  in_start delayed by L cycles
a_out  out  LANES*GF_BIT  a_in delayed by L cycles
b_out  out  LANES*GF_BIT  b_in delayed by L cycles
data_out  out  LANES*GF_BIT  result data
r  out  LANES*GF_BIT  accumulator, registered

Behaviour:
- Reset and latency
  - L = 1 + MUL_PIPE.
  - Asynchronous reset clears every register: all outputs, r and pipeline state are 0.
- Per-lane ops (valid cycle)
  - Let r' = 0 if in_start else r.
  - PASS: data_out = data_in; r unchanged.
  - LOAD: r = a*b.
  - MAC: r = r' ^ a*b.
  - ADD: data_out = data_in ^ a*r'; r unchanged, except r=0 when in_start.
  - EMIT: data_out = r'; r = 0.
  - Reserved modes 5-7: treated as PASS.
- Output registers
  - data_out is updated only by a valid PASS, ADD, EMIT or reserved op.
  - data_out holds for valid LOAD/MAC and for invalid cycles.
  - out_* and a_out/b_out are shifted every cycle regardless of valid.
- Invalid cycles (in_valid=0)
  - No r update, no data_out update.
  - out_valid=0 after L cycles.
- MUL_PIPE=1 pipeline
  - Stage 1 evaluates the multiplier and registers product, mode, start, valid and data_in.
  - Stage 2 writes r and data_out.
  - ADD needs r as a multiplier operand in stage 1. If stage 2 holds a valid r-writing op (LOAD, MAC, EMIT, or any op with start), stage 1 uses the stage-2 next-r value (forwarding).
  - Net effect: any op sequence gives bit-identical r/data_out streams to MUL_PIPE=0, delayed by one cycle.
- Lane independence
  - Lanes never interact.
  - The multiplier is purely combinational per lane.
- Reset during operation
  - Asserting rst_n low mid-stream clears all in-flight pipeline state.
  - out_valid is 0 from reset release until new valid input has propagated L cycles.

Decomposition:
- Shared package holds:
  - mode encodings (MODE_PASS=0 … MODE_EMIT=4);
  - GF16/GF256 reduction polynomials 0x13 / 0x11B;
  - GF_BIT legality check.
- One sub-module: gf_mul
  - Parameters: GF_BIT, TOWER.
  - Combinational, instantiated LANES times via generate.
- The PE top holds the pipeline, the forwarding mux and the accumulator.

Test Plan:
1. Single op, GF16, LANES=2, MUL_PIPE=0, lane0: start+LOAD a=2,b=9 -> r lane0=0x1; MAC a=3,b=7 -> r=0x8; EMIT -> data_out=0x8 and r=0; out_valid high 1 cycle after each op.
2. Forwarding, MUL_PIPE=1: back-to-back LOAD a=2,b=9 then ADD a=3,data_in=4 -> data_out lane0=0x7 (4^3*1) at cycle 3. Repeat with MUL_PIPE=0 -> same value at cycle 2.
3. GF256, GF_BIT=8, TOWER=0: start+LOAD a=0x57,b=0x83 -> r=0xC1; then MAC a=0x57,b=0x13 -> r=0xC1^0xFE=0x3F; EMIT -> data_out=0x3F. Check lanes stay independent with different lane1 operands.
4. Bubbles: LOAD, three invalid cycles with garbage operands, then EMIT -> r and data_out unchanged during the bubbles, out_valid low for exactly those 3 cycles, EMIT returns the LOAD product.
5. Reserved mode 6 with data_in=0xA -> data_out=0xA, r unchanged. PASS with in_start=1 -> r cleared to 0.
6. Reset mid-stream: assert rst_n low while a MAC is in stage 1 -> all outputs 0 immediately, no late write to r after release, out_valid=0 until new input has propagated L cycles.
